// File: rtl/write_back.sv
// Final pipeline stage: retires execute results to the register file, flags,
// data memory (via a waitrequest handshake) or the PC (branch redirect + drain).
module write_back #(
  parameter int REG_COUNT   = 16,
  parameter int PC_INDEX    = 15,
  parameter int FLAGS_INDEX = 14,
  localparam int RW         = $clog2(REG_COUNT)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [RW-1:0] in_destination,
  input  logic          in_destination_is_memory,
  input  logic [3:0]    in_flags,
  input  logic [31:0]   in_destination_value,
  input  logic [31:0]   in_adjustment,
  input  logic          in_has_flushed,
  output logic          in_hold,
  output logic [RW-1:0] rf_read_index,
  input  logic [31:0]   rf_read_value,
  output logic          rf_we,
  output logic [RW-1:0] rf_index,
  output logic [31:0]   rf_value,
  output logic          flags_we,
  output logic [3:0]    flags_value,
  output logic          mem_write,
  output logic [31:0]   mem_address,
  output logic [31:0]   mem_data,
  input  logic          mem_waitrequest,
  output logic          redirect_valid,
  output logic [31:0]   redirect_pc,
  output logic [31:0]   retired_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STORE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [RW-1:0] PC_REG = RW'(PC_INDEX);

  // The PC and flags aliases must be distinct, addressable registers.
  if (PC_INDEX >= REG_COUNT || FLAGS_INDEX >= REG_COUNT || PC_INDEX == FLAGS_INDEX) begin : g_bad_index
    $error("write_back: PC_INDEX/FLAGS_INDEX out of range or equal");
  end

  logic [1:0] state;
  logic       accept;
  logic       is_branch;

  // The instruction PC is carried for debug visibility only; retirement does not need it.
  logic       unused_pc;
  assign unused_pc = ^in_pc;

  assign in_hold       = (state == STORE);
  assign rf_read_index = in_destination;
  assign is_branch     = !in_destination_is_memory && (in_destination == PC_REG);
  assign accept        = in_valid && ((state == IDLE) || (state == DRAIN && in_has_flushed));

  // NOTE: every register here, including wide data, is cleared by the async
  // reset so mem_write drops the instant reset_n falls, even mid-store.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rf_we          <= 1'b0;
      rf_index       <= '0;
      rf_value       <= '0;
      flags_we       <= 1'b0;
      flags_value    <= '0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_data       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      retired_count  <= '0;
    end else begin
      // NOTE: non-blocking defaults make the strobes single-cycle pulses;
      // later assignments in this block override them for the same edge.
      rf_we          <= 1'b0;
      flags_we       <= 1'b0;
      redirect_valid <= 1'b0;

      case (state)
        IDLE, DRAIN: begin
          if (accept) begin
            retired_count <= retired_count + 32'd1;
            if (in_destination_is_memory) begin
              mem_address <= rf_read_value + in_adjustment;
              mem_data    <= in_destination_value;
              mem_write   <= 1'b1;
              state       <= STORE;
            end else if (is_branch) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= in_destination_value;
              flags_we       <= 1'b1;
              flags_value    <= in_flags;
              state          <= DRAIN;
            end else begin
              rf_we       <= 1'b1;
              rf_index    <= in_destination;
              rf_value    <= in_destination_value;
              flags_we    <= 1'b1;
              flags_value <= in_flags;
              state       <= IDLE;
            end
          end else if (state == DRAIN && in_has_flushed) begin
            state <= IDLE;
          end
        end
        STORE: begin
          if (!mem_waitrequest) begin
            mem_write <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_back.sv
// Directed self-checking bench for write_back: register, store, branch/drain,
// reset mid-store and wrap cases with hand-computed expectations.
module tb_write_back;

  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [RW-1:0] in_destination;
  logic          in_destination_is_memory;
  logic [3:0]    in_flags;
  logic [31:0]   in_destination_value;
  logic [31:0]   in_adjustment;
  logic          in_has_flushed;
  logic          in_hold;
  logic [RW-1:0] rf_read_index;
  logic [31:0]   rf_read_value;
  logic          rf_we;
  logic [RW-1:0] rf_index;
  logic [31:0]   rf_value;
  logic          flags_we;
  logic [3:0]    flags_value;
  logic          mem_write;
  logic [31:0]   mem_address;
  logic [31:0]   mem_data;
  logic          mem_waitrequest;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   retired_count;

  int compared   = 0;
  int mismatched = 0;

  write_back dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .in_valid                 (in_valid),
    .in_pc                    (in_pc),
    .in_destination           (in_destination),
    .in_destination_is_memory (in_destination_is_memory),
    .in_flags                 (in_flags),
    .in_destination_value     (in_destination_value),
    .in_adjustment            (in_adjustment),
    .in_has_flushed           (in_has_flushed),
    .in_hold                  (in_hold),
    .rf_read_index            (rf_read_index),
    .rf_read_value            (rf_read_value),
    .rf_we                    (rf_we),
    .rf_index                 (rf_index),
    .rf_value                 (rf_value),
    .flags_we                 (flags_we),
    .flags_value              (flags_value),
    .mem_write                (mem_write),
    .mem_address              (mem_address),
    .mem_data                 (mem_data),
    .mem_waitrequest          (mem_waitrequest),
    .redirect_valid           (redirect_valid),
    .redirect_pc              (redirect_pc),
    .retired_count            (retired_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] d, input logic mem,
                       input logic [31:0] val, input logic [3:0] fl, input logic fls);
    in_valid                 = v;
    in_destination           = d;
    in_destination_is_memory = mem;
    in_destination_value     = val;
    in_flags                 = fl;
    in_has_flushed           = fls;
  endtask

  initial begin
    reset_n         = 1'b0;
    in_pc           = 32'h0000_0100;
    in_adjustment   = 32'd0;
    rf_read_value   = 32'd0;
    mem_waitrequest = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    #12;
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_hold", 32'(in_hold), 32'd0);
    check("rst_redirect", 32'(redirect_valid), 32'd0);
    check("rst_count", retired_count, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Register result, then a back-to-back one.
    drive(1'b1, 4'd3, 1'b0, 32'h1234, 4'b0001, 1'b0);
    step();
    check("reg_rf_we", 32'(rf_we), 32'd1);
    check("reg_rf_index", 32'(rf_index), 32'd3);
    check("reg_rf_value", rf_value, 32'h1234);
    check("reg_flags_we", 32'(flags_we), 32'd1);
    check("reg_flags_value", 32'(flags_value), 32'd1);
    check("reg_count", retired_count, 32'd1);
    drive(1'b1, 4'd4, 1'b0, 32'h55, 4'b0010, 1'b0);
    step();
    check("b2b_rf_we", 32'(rf_we), 32'd1);
    check("b2b_rf_index", 32'(rf_index), 32'd4);
    check("b2b_flags_value", 32'(flags_value), 32'd2);
    check("b2b_count", retired_count, 32'd2);
    drive(1'b0, 4'd7, 1'b0, 32'h66, 4'b0000, 1'b0);
    step();
    check("idle_rf_we", 32'(rf_we), 32'd0);
    check("idle_flags_we", 32'(flags_we), 32'd0);
    check("idle_count", retired_count, 32'd2);

    // Store with three wait-state cycles.
    drive(1'b1, 4'd2, 1'b1, 32'hCAFE, 4'b1111, 1'b0);
    rf_read_value   = 32'h1000;
    in_adjustment   = 32'd8;
    mem_waitrequest = 1'b1;
    #1;
    check("rf_read_index", 32'(rf_read_index), 32'd2);
    step();
    drive(1'b0, 4'd9, 1'b0, 32'h0, 4'b0000, 1'b0);
    rf_read_value = 32'hDEAD_0000;
    in_adjustment = 32'h40;
    check("st_flags_we", 32'(flags_we), 32'd0);
    check("st_rf_we", 32'(rf_we), 32'd0);
    check("st_count", retired_count, 32'd3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("st_hold_%0d", i), 32'(in_hold), 32'd1);
      check($sformatf("st_write_%0d", i), 32'(mem_write), 32'd1);
      check($sformatf("st_addr_%0d", i), mem_address, 32'h1008);
      check($sformatf("st_data_%0d", i), mem_data, 32'hCAFE);
      if (i == 3) mem_waitrequest = 1'b0;
      step();
    end
    check("st_done_hold", 32'(in_hold), 32'd0);
    check("st_done_write", 32'(mem_write), 32'd0);

    // Branch, two wrong-path results discarded, flushed result writes.
    drive(1'b1, 4'd15, 1'b0, 32'h200, 4'b1000, 1'b0);
    step();
    check("br_redirect", 32'(redirect_valid), 32'd1);
    check("br_pc", redirect_pc, 32'h200);
    check("br_flags_we", 32'(flags_we), 32'd1);
    check("br_flags_value", 32'(flags_value), 32'h8);
    check("br_rf_we", 32'(rf_we), 32'd0);
    check("br_count", retired_count, 32'd4);
    drive(1'b1, 4'd5, 1'b0, 32'h77, 4'b0000, 1'b0);
    step();
    check("dr1_redirect", 32'(redirect_valid), 32'd0);
    check("dr1_rf_we", 32'(rf_we), 32'd0);
    drive(1'b1, 4'd6, 1'b0, 32'h88, 4'b0000, 1'b0);
    step();
    check("dr2_rf_we", 32'(rf_we), 32'd0);
    check("dr2_flags_we", 32'(flags_we), 32'd0);
    check("dr2_count", retired_count, 32'd4);
    drive(1'b1, 4'd6, 1'b0, 32'h99, 4'b0100, 1'b1);
    step();
    check("fl_rf_we", 32'(rf_we), 32'd1);
    check("fl_rf_index", 32'(rf_index), 32'd6);
    check("fl_rf_value", rf_value, 32'h99);
    check("fl_count", retired_count, 32'd5);

    // Flushed cycle without a result returns to IDLE.
    drive(1'b1, 4'd15, 1'b0, 32'h300, 4'b0000, 1'b0);
    step();
    check("br2_redirect", 32'(redirect_valid), 32'd1);
    drive(1'b0, 4'd0, 1'b0, 32'h0, 4'b0000, 1'b1);
    step();
    drive(1'b1, 4'd1, 1'b0, 32'h11, 4'b0000, 1'b0);
    step();
    check("post_idle_rf_we", 32'(rf_we), 32'd1);
    check("post_idle_count", retired_count, 32'd7);

    // A PC write on the flushed cycle re-enters DRAIN.
    drive(1'b1, 4'd15, 1'b0, 32'h400, 4'b0000, 1'b0);
    step();
    drive(1'b1, 4'd15, 1'b0, 32'h500, 4'b0000, 1'b1);
    step();
    check("rebr_redirect", 32'(redirect_valid), 32'd1);
    check("rebr_pc", redirect_pc, 32'h500);
    drive(1'b1, 4'd2, 1'b0, 32'h22, 4'b0000, 1'b0);
    step();
    check("rebr_discard", 32'(rf_we), 32'd0);
    check("rebr_count", retired_count, 32'd9);
    drive(1'b0, 4'd0, 1'b0, 32'h0, 4'b0000, 1'b1);
    step();

    // Store address wrap with zero wait states.
    drive(1'b1, 4'd1, 1'b1, 32'h5A5A, 4'b0000, 1'b0);
    rf_read_value   = 32'hFFFF_FFFC;
    in_adjustment   = 32'd8;
    mem_waitrequest = 1'b0;
    step();
    drive(1'b0, 4'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
    check("wrap_write", 32'(mem_write), 32'd1);
    check("wrap_addr", mem_address, 32'h4);
    check("wrap_hold", 32'(in_hold), 32'd1);
    step();
    check("wrap_done_write", 32'(mem_write), 32'd0);
    check("wrap_done_hold", 32'(in_hold), 32'd0);
    check("wrap_count", retired_count, 32'd10);

    // Reset asserted mid-store.
    drive(1'b1, 4'd2, 1'b1, 32'hBEEF, 4'b0000, 1'b0);
    rf_read_value   = 32'h2000;
    in_adjustment   = 32'd0;
    mem_waitrequest = 1'b1;
    step();
    drive(1'b0, 4'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
    check("mid_write", 32'(mem_write), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_write", 32'(mem_write), 32'd0);
    check("mid_rst_hold", 32'(in_hold), 32'd0);
    check("mid_rst_count", retired_count, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check("post_rst_hold", 32'(in_hold), 32'd0);
    check("post_rst_write", 32'(mem_write), 32'd0);
    check("post_rst_count", retired_count, 32'd0);
    mem_waitrequest = 1'b0;

    // Retirement counter wrap from FFFF_FFFF.
    force dut.retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count;
    #1;
    check("pre_wrap_count", retired_count, 32'hFFFF_FFFF);
    drive(1'b1, 4'd3, 1'b0, 32'h1, 4'b0000, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
    check("count_wrap", retired_count, 32'd0);
    check("count_wrap_rf_we", 32'(rf_we), 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
